// File: rtl/charge_inj_pulse_sequencer_pkg.sv
// Shared definitions for the charge-injection pulse sequencer: sizes,
// FSM state type, captured-configuration record and a width helper.
package ci_pkg;

    localparam int N_CH      = 4;
    localparam int FINE_BITS = 5;
    localparam int SER_W     = 2 ** FINE_BITS;
    localparam int COARSE_W  = 8;
    localparam int WIDTH_W   = 6;
    localparam int BURST_W   = 4;

    // Word index must hold coarse + 16 * (gap + 1) + 2 without wrapping.
    localparam int WORD_W    = COARSE_W + BURST_W + 1;
    localparam int SLOT_W    = WORD_W + FINE_BITS;
    localparam int REM_W     = BURST_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [COARSE_W-1:0]  coarse;
        logic [FINE_BITS-1:0] fine;
        logic [WIDTH_W-1:0]   width;
        logic [BURST_W-1:0]   burst;
        logic [COARSE_W-1:0]  gap;
        logic [N_CH-1:0]      ch_en;
    } cfg_t;

    // A zero width code still produces a single-slot pulse.
    function automatic logic [WIDTH_W-1:0] eff_width(input logic [WIDTH_W-1:0] w);
        return (w == '0) ? WIDTH_W'(1) : w;
    endfunction

endpackage

// File: rtl/charge_inj_pulse_sequencer_word_mask.sv
// Combinational slot mask for one pulse over one serializer word:
// bit i is set when start <= base + i < end.
module ci_word_mask
    import ci_pkg::*;
(
    input  logic              valid_i,
    input  logic [SLOT_W-1:0] base_i,
    input  logic [SLOT_W-1:0] start_i,
    input  logic [SLOT_W-1:0] end_i,
    output logic [SER_W-1:0]  mask_o
);

    for (genvar i = 0; i < SER_W; i++) begin : g_bit
        logic [SLOT_W-1:0] slot;
        assign slot      = base_i + SLOT_W'(i);
        assign mask_o[i] = valid_i && (slot >= start_i) && (slot < end_i);
    end

endmodule

// File: rtl/charge_inj_pulse_sequencer.sv
// Multi-channel charge-injection pulse sequencer. On an accepted cmd it
// emits one SER_W-bit pattern word per channel per clk40 cycle describing a
// burst of pulses with coarse/fine delay and fine-step width.
// Optional build macro CI_PULSE_COUNT_EN adds a saturating pulse_count output.
//
// state | meaning
// IDLE  | pattern held at zero, waiting for cmd
// RUN   | presenting one word per cycle until the word holding the final slot
module charge_inj_pulse_sequencer
    import ci_pkg::*;
(
    input  logic                  clk40,
    input  logic                  reset,
    input  logic                  cmd,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [COARSE_W-1:0]   coarse_delay,
    input  logic [FINE_BITS-1:0]  fine_delay,
    input  logic [WIDTH_W-1:0]    pulse_width,
    input  logic [BURST_W-1:0]    burst_count,
    input  logic [COARSE_W-1:0]   burst_gap,
    output logic [N_CH*SER_W-1:0] pattern,
    output logic                  busy,
    output logic                  done,
    output logic                  cmd_dropped
`ifdef CI_PULSE_COUNT_EN
    ,
    output logic [15:0]           pulse_count
`endif
);

    state_t               state_q;
    cfg_t                 cfg_q;
    cfg_t                 cfg_live;
    cfg_t                 cfg_eff;

    logic [WORD_W-1:0]    word_q, word_eff;
    logic [WORD_W-1:0]    nxt_q, nxt_eff;
    logic [WORD_W-1:0]    h0_q, h0_eff;
    logic [WORD_W-1:0]    h1_q, h1_eff;
    logic                 h0v_q, h0v_eff;
    logic                 h1v_q, h1v_eff;
    logic [REM_W-1:0]     rem_q, rem_eff;
    logic [WORD_W-1:0]    last_q, last_calc, last_eff;

    logic [COARSE_W:0]    period_eff;
    logic [WIDTH_W-1:0]   wid_eff;
    logic [SLOT_W-1:0]    last_slot;
    logic [SLOT_W-1:0]    base_slot;
    logic [SLOT_W-1:0]    new_start, new_end;
    logic [SLOT_W-1:0]    h0_start, h0_end;
    logic [SLOT_W-1:0]    h1_start, h1_end;

    logic                 idle;
    logic                 advance;
    logic                 starts_now;
    logic [SER_W-1:0]     m_new, m_h0, m_h1, word_bits;
    logic [N_CH*SER_W-1:0] pattern_d;

    logic [N_CH*SER_W-1:0] pattern_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 cmd_dropped_q;

    assign idle     = (state_q == IDLE);
    assign cfg_live = '{coarse: coarse_delay, fine: fine_delay, width: pulse_width,
                        burst: burst_count, gap: burst_gap, ch_en: ch_en};

    // In IDLE the first word is built straight from the live inputs so it can
    // appear in the cycle right after acceptance; in RUN the captured copy is used.
    always_comb begin
        cfg_eff    = idle ? cfg_live : cfg_q;
        word_eff   = idle ? '0 : word_q + WORD_W'(1);
        nxt_eff    = idle ? WORD_W'(cfg_eff.coarse) : nxt_q;
        rem_eff    = idle ? REM_W'(cfg_eff.burst) + REM_W'(1) : rem_q;
        h0_eff     = idle ? '0 : h0_q;
        h0v_eff    = idle ? 1'b0 : h0v_q;
        h1_eff     = idle ? '0 : h1_q;
        h1v_eff    = idle ? 1'b0 : h1v_q;
        period_eff = (COARSE_W+1)'(cfg_eff.gap) + (COARSE_W+1)'(1);
        wid_eff    = eff_width(cfg_eff.width);
        last_slot  = {WORD_W'(cfg_eff.coarse) + WORD_W'(cfg_eff.burst) * WORD_W'(period_eff),
                      cfg_eff.fine} + SLOT_W'(wid_eff) - SLOT_W'(1);
        last_calc  = last_slot[SLOT_W-1:FINE_BITS];
        last_eff   = idle ? last_calc : last_q;
    end

    assign advance    = (idle && cmd) || (!idle && !done_q);
    assign starts_now = (rem_eff != '0) && (nxt_eff == word_eff);

    // Pulses are at least one word apart and at most 63 slots wide, so only the
    // pulse starting in this word and the two most recent earlier ones can reach it.
    assign base_slot = {word_eff, {FINE_BITS{1'b0}}};
    assign new_start = {nxt_eff, cfg_eff.fine};
    assign new_end   = new_start + SLOT_W'(wid_eff);
    assign h0_start  = {h0_eff, cfg_eff.fine};
    assign h0_end    = h0_start + SLOT_W'(wid_eff);
    assign h1_start  = {h1_eff, cfg_eff.fine};
    assign h1_end    = h1_start + SLOT_W'(wid_eff);

    ci_word_mask u_mask_new (
        .valid_i (starts_now),
        .base_i  (base_slot),
        .start_i (new_start),
        .end_i   (new_end),
        .mask_o  (m_new)
    );

    ci_word_mask u_mask_h0 (
        .valid_i (h0v_eff),
        .base_i  (base_slot),
        .start_i (h0_start),
        .end_i   (h0_end),
        .mask_o  (m_h0)
    );

    ci_word_mask u_mask_h1 (
        .valid_i (h1v_eff),
        .base_i  (base_slot),
        .start_i (h1_start),
        .end_i   (h1_end),
        .mask_o  (m_h1)
    );

    assign word_bits = m_new | m_h0 | m_h1;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign pattern_d[c*SER_W +: SER_W] = cfg_eff.ch_en[c] ? word_bits : '0;
    end

    // Sequencer FSM: capture config on accept, step one word per cycle, drop back to IDLE after done
    always_ff @(posedge clk40) begin
        if (!reset) begin
            state_q       <= IDLE;
            cfg_q         <= '0;
            word_q        <= '0;
            nxt_q         <= '0;
            rem_q         <= '0;
            h0_q          <= '0;
            h0v_q         <= 1'b0;
            h1_q          <= '0;
            h1v_q         <= 1'b0;
            last_q        <= '0;
            pattern_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cmd_dropped_q <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            cmd_dropped_q <= 1'b0;
            if (advance) begin
                pattern_q <= pattern_d;
                word_q    <= word_eff;
                last_q    <= last_eff;
                done_q    <= (word_eff == last_eff);
                busy_q    <= 1'b1;
                if (starts_now) begin
                    h1_q  <= h0_eff;
                    h1v_q <= h0v_eff;
                    h0_q  <= nxt_eff;
                    h0v_q <= 1'b1;
                    nxt_q <= nxt_eff + WORD_W'(period_eff);
                    rem_q <= rem_eff - REM_W'(1);
                end else begin
                    h1_q  <= h1_eff;
                    h1v_q <= h1v_eff;
                    h0_q  <= h0_eff;
                    h0v_q <= h0v_eff;
                    nxt_q <= nxt_eff;
                    rem_q <= rem_eff;
                end
            end
            case (state_q)
                IDLE: begin
                    if (cmd) begin
                        state_q <= RUN;
                        cfg_q   <= cfg_live;
                    end
                end
                RUN: begin
                    cmd_dropped_q <= cmd;
                    if (done_q) begin
                        state_q   <= IDLE;
                        pattern_q <= '0;
                        busy_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pattern     = pattern_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cmd_dropped = cmd_dropped_q;

`ifdef CI_PULSE_COUNT_EN
    logic [15:0] pulse_count_q;

    // Count each pulse as its first word is loaded, only if some channel carries it
    always_ff @(posedge clk40) begin
        if (!reset) begin
            pulse_count_q <= '0;
        end else if (advance && starts_now && (|cfg_eff.ch_en) && (pulse_count_q != 16'hFFFF)) begin
            pulse_count_q <= pulse_count_q + 16'd1;
        end
    end

    assign pulse_count = pulse_count_q;
`endif

endmodule

// File: tb/tb_charge_inj_pulse_sequencer.sv
// Self-checking bench for charge_inj_pulse_sequencer: a brute-force slot model
// fills a scoreboard at each command, entries are popped one per clk40 cycle.
module tb_charge_inj_pulse_sequencer;

    logic         clk40 = 1'b0;
    logic         reset;
    logic         cmd;
    logic [3:0]   ch_en;
    logic [7:0]   coarse_delay;
    logic [4:0]   fine_delay;
    logic [5:0]   pulse_width;
    logic [3:0]   burst_count;
    logic [7:0]   burst_gap;
    logic [127:0] pattern;
    logic         busy;
    logic         done;
    logic         cmd_dropped;
`ifdef CI_PULSE_COUNT_EN
    logic [15:0]  pulse_count;
    logic [15:0]  pc_before;
`endif

    always #5 clk40 = ~clk40;

    charge_inj_pulse_sequencer dut (
        .clk40        (clk40),
        .reset        (reset),
        .cmd          (cmd),
        .ch_en        (ch_en),
        .coarse_delay (coarse_delay),
        .fine_delay   (fine_delay),
        .pulse_width  (pulse_width),
        .burst_count  (burst_count),
        .burst_gap    (burst_gap),
        .pattern      (pattern),
        .busy         (busy),
        .done         (done),
        .cmd_dropped  (cmd_dropped)
`ifdef CI_PULSE_COUNT_EN
        ,
        .pulse_count  (pulse_count)
`endif
    );

    typedef struct {
        logic [127:0] pat;
        logic         busy;
        logic         done;
        logic         drop;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int model_last(int co, int fi, int wi, int bu, int ga);
        int w;
        w = (wi == 0) ? 1 : wi;
        return ((co + bu * (ga + 1)) * 32 + fi + w - 1) / 32;
    endfunction

    function automatic logic [31:0] model_word(int co, int fi, int wi, int bu, int ga, int j);
        logic [31:0] r;
        int w, s0;
        r = '0;
        w = (wi == 0) ? 1 : wi;
        for (int n = 0; n <= bu; n++) begin
            s0 = (co + n * (ga + 1)) * 32 + fi;
            for (int s = s0; s < s0 + w; s++)
                if (s / 32 == j) r[s % 32] = 1'b1;
        end
        return r;
    endfunction

    task automatic chk_bit(input string tag, input int cyc, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s cyc %0d: observed %0b expected %0b", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input int cyc, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s cyc %0d: observed %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // inj: cycle (relative to k) in which a stray cmd is driven, 0 = none
    // rst_at: cycle in which reset is held low, 0 = none
    // chain: stop after the done word so the next command lands in the first idle cycle
    task automatic run_case(input string tag, input int co, input int fi, input int wi,
                            input int bu, input int ga, input logic [3:0] en,
                            input int inj, input int rst_at, input bit chain);
        int last, nent, c;
        exp_t e;
        logic [31:0] w;
        last = model_last(co, fi, wi, bu, ga);
        nent = chain ? last + 1 : last + 2;
        if (rst_at > 0) nent = rst_at + 2;
        for (int j = 0; j < nent; j++) begin
            c = j + 1;
            e.pat  = '0;
            e.busy = 1'b0;
            e.done = 1'b0;
            e.drop = (inj > 0) && (c == inj + 1);
            if (!(rst_at > 0 && c > rst_at) && j <= last) begin
                w = model_word(co, fi, wi, bu, ga, j);
                for (int ch = 0; ch < 4; ch++)
                    if (en[ch]) e.pat[ch*32 +: 32] = w;
                e.busy = 1'b1;
                e.done = (j == last);
            end
            sb.push_back(e);
        end
        coarse_delay = 8'(co);
        fine_delay   = 5'(fi);
        pulse_width  = 6'(wi);
        burst_count  = 4'(bu);
        burst_gap    = 8'(ga);
        ch_en        = en;
        cmd          = 1'b1;
        @(posedge clk40);
        #1;
        cmd = 1'b0;
        c = 1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk_vec({tag, ".pattern"}, c, pattern, e.pat);
            chk_bit({tag, ".busy"}, c, busy, e.busy);
            chk_bit({tag, ".done"}, c, done, e.done);
            chk_bit({tag, ".cmd_dropped"}, c, cmd_dropped, e.drop);
            if (c == inj) begin
                cmd        = 1'b1;
                fine_delay = ~fine_delay;
                ch_en      = ~ch_en;
            end else begin
                cmd = 1'b0;
            end
            reset = (c == rst_at) ? 1'b0 : 1'b1;
            @(posedge clk40);
            #1;
            c++;
        end
    endtask

    initial begin
        reset        = 1'b0;
        cmd          = 1'b0;
        ch_en        = '0;
        coarse_delay = '0;
        fine_delay   = '0;
        pulse_width  = '0;
        burst_count  = '0;
        burst_gap    = '0;
        repeat (3) @(posedge clk40);
        #1;
        chk_vec("reset.pattern", 0, pattern, 128'd0);
        chk_bit("reset.busy", 0, busy, 1'b0);
        chk_bit("reset.done", 0, done, 1'b0);
        chk_bit("reset.cmd_dropped", 0, cmd_dropped, 1'b0);
`ifdef CI_PULSE_COUNT_EN
        chk_vec("reset.pulse_count", 0, 128'(pulse_count), 128'd0);
`endif
        reset = 1'b1;
        @(posedge clk40);
        #1;

        run_case("min",       0,  0, 1, 0, 0, 4'b0001, 0, 0, 1'b0);
        run_case("straddle",  2, 30, 5, 0, 0, 4'b0001, 0, 0, 1'b0);
`ifdef CI_PULSE_COUNT_EN
        pc_before = pulse_count;
`endif
        run_case("burst",     0,  5, 4, 2, 3, 4'b1010, 0, 0, 1'b0);
`ifdef CI_PULSE_COUNT_EN
        chk_vec("burst.pulse_count", 0, 128'(pulse_count), 128'(pc_before + 16'd3));
`endif
        run_case("burst_cmd", 0,  5, 4, 2, 3, 4'b1010, 3, 0, 1'b0);
        run_case("burst_rst", 0,  5, 4, 2, 3, 4'b1010, 0, 2, 1'b0);
        run_case("burst_re",  0,  5, 4, 2, 3, 4'b1010, 0, 0, 1'b0);
        run_case("width0",    1, 31, 0, 0, 0, 4'b0100, 0, 0, 1'b0);
`ifdef CI_PULSE_COUNT_EN
        pc_before = pulse_count;
`endif
        run_case("ch_off",    0,  5, 4, 2, 3, 4'b0000, 0, 0, 1'b0);
`ifdef CI_PULSE_COUNT_EN
        chk_vec("ch_off.pulse_count", 0, 128'(pulse_count), 128'(pc_before));
`endif
        run_case("overlap",   0, 20, 63, 3, 0, 4'b1111, 0, 0, 1'b1);
        run_case("b2b",       1,  3, 7, 1, 1, 4'b0011, 0, 0, 1'b0);
        run_case("widest",  255, 31, 63, 15, 255, 4'b1001, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/charge_inj_pulse_sequencer.md
Name: charge_inj_pulse_sequencer

Overview:
- Multi-channel successor to the single-channel charge-injection pulse generator.
- On each accepted charge-injection command, produces a burst of injection pulses.
- Each pulse has programmable coarse delay (clk40 periods), fine delay (1/32 period) and width (fine steps).
- Output is, per clk40 cycle, one parallel pattern word per channel for a downstream 32:1 serializer at 1280 MHz. The block is entirely in the clk40 domain.

Parameters:
- N_CH, 4, number of injection channels.
- FINE_BITS, 5, fine-delay code width; SER_W = 2**FINE_BITS = 32 slots per word.
- COARSE_W, 8, coarse-delay and burst-gap width.
- WIDTH_W, 6, pulse-width code width (fine steps).
- BURST_W, 4, burst-count code width.

Ports:
- clk40  in  1  40 MHz clock.
- reset  in  1  synchronous, active-low.
- cmd  in  1  charge-injection command strobe.
- ch_en  in  N_CH  channel enable mask.
- coarse_delay  in  COARSE_W  delay in whole clk40 periods.
- fine_delay  in  FINE_BITS  delay in fine slots.
- pulse_width  in  WIDTH_W  pulse width in fine slots.
- burst_count  in  BURST_W  pulses per burst minus one.
- burst_gap  in  COARSE_W  pulse spacing minus one, in clk40 periods.
- pattern  out  N_CH*SER_W  channel c occupies bits [c*SER_W +: SER_W]; bit 0 is serialized first.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle strobe with the final word.
- cmd_dropped  out  1  one-cycle strobe when cmd is ignored.

Behaviour:
- Reset (reset=0 at a clk40 edge): pattern=0, busy=0, done=0, cmd_dropped=0, state IDLE. This overrides any sequence in progress, with no partial output afterwards.
- States: IDLE, RUN.
  - IDLE -> RUN when cmd=1 at an edge (acceptance cycle k).
  - RUN -> IDLE at the edge ending the final word cycle.
- All configuration inputs and ch_en are captured in cycle k. Changes during RUN are ignored.
- Slot numbering:
  - The word on pattern in cycle k+1+j covers absolute slots 32j..32j+31.
  - Bit i of that word is slot 32j+i.
- Pulse timing:
  - Pulse n (n = 0..burst_count) starts at slot S_n = (coarse_delay + n*(burst_gap+1))*32 + fine_delay.
  - It occupies W slots, where W = max(pulse_width, 1).
  - A pulse may straddle word boundaries (up to 3 words).
  - Overlapping pulses are OR-merged.
- Internal arithmetic is wide enough that no start or end slot wraps.
- Enabled channels carry identical patterns. Disabled channels output all zeros, but timing, busy and done are unaffected.
- busy:
  - Low in cycle k.
  - High from cycle k+1 through the cycle presenting the word that contains the last slot of the final pulse.
  - Leading empty words (coarse delay) count as busy.
- done is high exactly in that last word cycle. Outside RUN, pattern=0.
- cmd=1 while in RUN: ignored, cmd_dropped=1 next cycle, sequence undisturbed.
- A cmd in the first cycle after done is accepted.

Optional Feature:
- Macro CI_PULSE_COUNT_EN.
- Defined: adds output pulse_count [15:0].
  - Increments by one at the start slot's word of each emitted pulse.
  - Counts only when at least one channel is enabled.
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package ci_pkg holds:
  - SER_W derivation;
  - the state enum (IDLE, RUN);
  - a captured-configuration struct (coarse, fine, width, burst, gap, ch_en).
- One sub-module, ci_word_mask: combinational 32-bit mask generator. Given the current word's base slot and a pulse's start/end slots, it sets bit i when start <= base+i < start+W.

Test Plan:
- Minimum pulse: coarse=0, fine=0, width=1, burst=0, ch_en=4'b0001, cmd at cycle k.
  - Cycle k+1: pattern[0]=1 and all other bits 0; busy=1, done=1.
  - Cycle k+2: busy=0.
- Straddling pulse: coarse=2, fine=30, width=5.
  - Words j=0,1 all zeros.
  - j=2 has ch0 bits 30,31 set; j=3 has bits 0..2 set.
  - done at cycle k+4; busy high for 4 cycles.
- Burst: burst=2, gap=3, coarse=0, fine=5, width=4, ch_en=4'b1010.
  - Channels 1 and 3 have bits 5..8 set in words j=0,4,8; all other words are zero; channels 0 and 2 stay zero.
  - done at k+9.
- cmd pulsed at k+3 during a run of the burst case: cmd_dropped=1 at k+4, output identical to the undisturbed run. Changing fine_delay mid-run has no effect.
- reset=0 at the edge ending cycle k+2 of the burst case: pattern=0 and busy=0 from cycle k+3 onward. After reset returns to 1, cmd reruns the full sequence correctly.
- width=0 behaves as width=1.
- ch_en=0: pattern stays zero but busy and done timing are unchanged. With CI_PULSE_COUNT_EN defined, pulse_count is unchanged in this case, and increases by 3 for the burst case.
